apple_gen: RTL and testbench
============================

Name: apple_gen

Overview:
- Food (apple) generator for the snake game.
- Places an apple at a pseudo-random interior grid cell and watches the snake head for a hit.
- On a hit, it produces the add_cube grow request for the snake-motion block, counts the apple, and re-places.
- Also supplies an apple hit flag for the pixel scan, for the colour/VGA stage.

Parameters:
X_MIN, 1, lowest legal apple column (inside wall)
X_MAX, 38, highest legal apple column
Y_MIN, 1, lowest legal apple row
Y_MAX, 28, highest legal apple row
LFSR_SEED, 16'hACE1, LFSR load value at reset (must be non-zero)
ADD_HOLD, 4, cycles add_cube stays high per eaten apple (>=1)
MAX_TRIES, 63, rejected draws before fallback placement

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
game_status  in  2  2'b00 RESTART, 2'b10 PLAY, other codes = hold/pause
head_x  in  6  snake head column (grid units)
head_y  in  6  snake head row (grid units)
x_pos  in  10  scan pixel column
y_pos  in  10  scan pixel row
apple_x  out  6  current apple column
apple_y  out  6  current apple row
apple_valid  out  1  apple placed and visible
add_cube  out  1  grow request to snake block, level held ADD_HOLD cycles
eat_count  out  8  apples eaten this game, saturating
apple_pix  out  1  scan pixel lies in apple cell

Behaviour:
- All state updates on posedge clk.
- rst has priority over everything.
- Reset values:
  - apple_x=0, apple_y=0, apple_valid=0, add_cube=0, eat_count=0.
  - lfsr=LFSR_SEED, try_cnt=0, hold_cnt=0, state=IDLE.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances every cycle except during rst; free-runs through RESTART, so successive games differ.
  - Candidate draw: cx=lfsr[5:0], cy=lfsr[13:8].
- Candidate acceptance requires all three:
  - X_MIN<=cx<=X_MAX
  - Y_MIN<=cy<=Y_MAX
  - !(cx==head_x && cy==head_y)
- Only head avoidance is required. Body overlap is permitted; the renderer gives snake priority.
- game_status==RESTART (not rst) forces, on the next edge:
  - state=IDLE, apple_valid=0, add_cube=0, eat_count=0, hold_cnt=0, try_cnt=0.
  - apple_x and apple_y retain their values.
- States:
  - IDLE: apple_valid=0. Goes to PLACE when game_status==PLAY.
  - PLACE: one candidate per cycle.
    - Accept: latch apple_x/apple_y, apple_valid=1 next cycle, go to ACTIVE, try_cnt=0.
    - Reject: try_cnt+1.
    - When try_cnt==MAX_TRIES and the draw is rejected: fallback cell (X_MIN,Y_MIN), or (X_MAX,Y_MAX) if the head occupies (X_MIN,Y_MIN); then ACTIVE.
    - Worst-case placement latency is MAX_TRIES+1 cycles.
  - ACTIVE: when game_status==PLAY and head_x==apple_x and head_y==apple_y:
    - Next edge: apple_valid=0, add_cube=1, hold_cnt=ADD_HOLD-1, eat_count+1 (saturates at 255), go to EAT.
    - Latency from matching head to add_cube high: 1 cycle.
  - EAT: add_cube=1 while hold_cnt>0, decrementing. When hold_cnt==0, add_cube=0 next edge and go to PLACE.
    - add_cube is high for exactly ADD_HOLD consecutive cycles, then low at least 1 cycle. This gives one rising edge per apple to the downstream edge-detect handshake.
- Pause (game_status neither RESTART nor PLAY):
  - PLACE and ACTIVE freeze; no hit detection; apple_valid holds.
  - EAT continues its countdown so add_cube always deasserts.
  - IDLE stays IDLE.
- Simultaneous events:
  - rst beats RESTART, which beats everything else.
  - A hit in the same cycle PLACE accepts is not detected until ACTIVE (cannot occur for the head cell by construction).
- apple_pix is combinational: apple_valid && x_pos<640 && y_pos<480 && x_pos[9:4]==apple_x && y_pos[9:4]==apple_y.
- Widths: compares are unsigned 6-bit; eat_count increments only if !=8'hFF.

Test Plan:
- Reset check: assert rst 3 cycles with game_status=2'b10 → all outputs 0, state IDLE. Release rst → apple_valid=1 within 64 cycles; apple_x in 1..38, apple_y in 1..28, and (apple_x,apple_y)!=(head_x,head_y)=(10,5).
- Eat: after placement, drive head to (apple_x,apple_y) → add_cube high 1 cycle later for exactly 4 cycles, eat_count 0→1, apple_valid low during EAT. New valid apple appears within 64 cycles of add_cube falling.
- Restart mid-EAT: game_status=2'b00 on 2nd add_cube cycle → next edge add_cube=0, apple_valid=0, eat_count=0. Return to 2'b10 → new placement.
- Pause: game_status=2'b01 while ACTIVE, head on apple → no add_cube, eat_count unchanged. Pause during EAT → add_cube still drops after 4 cycles total.
- Saturation: force 256 hits → eat_count stays 255, add_cube still pulses each hit.
- apple_pix: apple at (20,15); scan x_pos=320..335, y_pos=240..255 → 1. x_pos=336 → 0. apple_valid=0 → 0.

Source files
------------

// File: rtl/apple_gen_if.sv
// Game-facing bundle of the apple generator: snake head and scan position in,
// apple placement, grow request, score and pixel hit flag out.
interface apple_gen_if;
  logic [1:0] game_status;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [5:0] apple_x;
  logic [5:0] apple_y;
  logic       apple_valid;
  logic       add_cube;
  logic [7:0] eat_count;
  logic       apple_pix;

  modport master (
    output game_status, head_x, head_y, x_pos, y_pos,
    input  apple_x, apple_y, apple_valid, add_cube, eat_count, apple_pix
  );

  modport slave (
    input  game_status, head_x, head_y, x_pos, y_pos,
    output apple_x, apple_y, apple_valid, add_cube, eat_count, apple_pix
  );
endinterface

// File: rtl/apple_gen.sv
// Snake-game food generator: LFSR placement on interior cells avoiding the head,
// hit detection, held add_cube grow request, saturating apple count, pixel flag.
module apple_gen #(
  parameter int unsigned X_MIN     = 1,
  parameter int unsigned X_MAX     = 38,
  parameter int unsigned Y_MIN     = 1,
  parameter int unsigned Y_MAX     = 28,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned ADD_HOLD  = 4,
  parameter int unsigned MAX_TRIES = 63
) (
  input  logic        clk,
  input  logic        rst,
  apple_gen_if.slave  bus
);

  localparam int unsigned HOLD_W = (ADD_HOLD > 1) ? $clog2(ADD_HOLD) : 1;
  localparam int unsigned TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [5:0]        X_LO       = 6'(X_MIN);
  localparam logic [5:0]        X_HI       = 6'(X_MAX);
  localparam logic [5:0]        Y_LO       = 6'(Y_MIN);
  localparam logic [5:0]        Y_HI       = 6'(Y_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(ADD_HOLD - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST   = TRY_W'(MAX_TRIES);
  localparam logic [15:0]       LFSR_TAPS  = 16'hB400;
  localparam logic [1:0]        GS_RESTART = 2'b00;
  localparam logic [1:0]        GS_PLAY    = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLACE  = 2'd1,
    ACTIVE = 2'd2,
    EAT    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [TRY_W-1:0]    try_cnt_q, try_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [5:0]          apple_x_q, apple_x_d;
  logic [5:0]          apple_y_q, apple_y_d;
  logic                apple_valid_q, apple_valid_d;
  logic                add_cube_q, add_cube_d;
  logic [7:0]          eat_count_q, eat_count_d;

  logic [5:0]          cand_x_s;
  logic [5:0]          cand_y_s;
  logic                cand_ok_s;
  logic                head_on_min_s;
  logic                head_on_apple_s;
  logic                play_s;
  logic                restart_s;

  // Candidate qualification and status decode
  always_comb begin
    cand_x_s        = lfsr_q[5:0];
    cand_y_s        = lfsr_q[13:8];
    play_s          = (bus.game_status == GS_PLAY);
    restart_s       = (bus.game_status == GS_RESTART);
    head_on_min_s   = (bus.head_x == X_LO) && (bus.head_y == Y_LO);
    head_on_apple_s = (bus.head_x == apple_x_q) && (bus.head_y == apple_y_q);
    cand_ok_s       = (cand_x_s >= X_LO) && (cand_x_s <= X_HI) &&
                      (cand_y_s >= Y_LO) && (cand_y_s <= Y_HI) &&
                      !((cand_x_s == bus.head_x) && (cand_y_s == bus.head_y));
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    try_cnt_d     = try_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    apple_x_d     = apple_x_q;
    apple_y_d     = apple_y_q;
    apple_valid_d = apple_valid_q;
    add_cube_d    = add_cube_q;
    eat_count_d   = eat_count_q;
    // The LFSR free-runs through RESTART so consecutive games differ
    lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    if (restart_s) begin
      state_d       = IDLE;
      apple_valid_d = 1'b0;
      add_cube_d    = 1'b0;
      eat_count_d   = 8'h00;
      hold_cnt_d    = '0;
      try_cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          apple_valid_d = 1'b0;
          if (play_s) begin
            state_d = PLACE;
          end else begin
            state_d = IDLE;
          end
        end
        PLACE: begin
          if (!play_s) begin
            state_d = PLACE;
          end else if (cand_ok_s) begin
            apple_x_d     = cand_x_s;
            apple_y_d     = cand_y_s;
            apple_valid_d = 1'b1;
            try_cnt_d     = '0;
            state_d       = ACTIVE;
          end else if (try_cnt_q == TRY_LAST) begin
            apple_x_d     = head_on_min_s ? X_HI : X_LO;
            apple_y_d     = head_on_min_s ? Y_HI : Y_LO;
            apple_valid_d = 1'b1;
            try_cnt_d     = '0;
            state_d       = ACTIVE;
          end else begin
            try_cnt_d = try_cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          if (play_s && head_on_apple_s) begin
            apple_valid_d = 1'b0;
            add_cube_d    = 1'b1;
            hold_cnt_d    = HOLD_LOAD;
            eat_count_d   = (eat_count_q != 8'hFF) ? (eat_count_q + 8'h01) : eat_count_q;
            state_d       = EAT;
          end else begin
            state_d = ACTIVE;
          end
        end
        EAT: begin
          // Counts down even while paused so the grow request always ends
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
            add_cube_d = 1'b1;
          end else begin
            add_cube_d = 1'b0;
            state_d    = PLACE;
          end
        end
        default: begin
          state_d       = IDLE;
          apple_valid_d = 1'b0;
          add_cube_d    = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_SEED;
      try_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      apple_x_q     <= 6'd0;
      apple_y_q     <= 6'd0;
      apple_valid_q <= 1'b0;
      add_cube_q    <= 1'b0;
      eat_count_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      try_cnt_q     <= try_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      apple_x_q     <= apple_x_d;
      apple_y_q     <= apple_y_d;
      apple_valid_q <= apple_valid_d;
      add_cube_q    <= add_cube_d;
      eat_count_q   <= eat_count_d;
    end
  end

  assign bus.apple_x     = apple_x_q;
  assign bus.apple_y     = apple_y_q;
  assign bus.apple_valid = apple_valid_q;
  assign bus.add_cube    = add_cube_q;
  assign bus.eat_count   = eat_count_q;
  assign bus.apple_pix   = apple_valid_q &&
                           (bus.x_pos < 10'd640) && (bus.y_pos < 10'd480) &&
                           (bus.x_pos[9:4] == apple_x_q) && (bus.y_pos[9:4] == apple_y_q);

endmodule

// File: tb/tb_apple_gen.sv
// Randomized bench for apple_gen, compared every cycle against a game-level
// reference model (phase + remaining grow cycles + reject count).
module tb_apple_gen;
  localparam int X_MIN     = 1;
  localparam int X_MAX     = 38;
  localparam int Y_MIN     = 1;
  localparam int Y_MAX     = 28;
  localparam int ADD_HOLD  = 4;
  localparam int MAX_TRIES = 63;
  localparam int SEED      = 'hACE1;

  localparam int M_IDLE    = 0;
  localparam int M_PLACING = 1;
  localparam int M_SHOWING = 2;
  localparam int M_EATING  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  int m_lfsr, m_mode, m_ax, m_ay, m_valid, m_add_left, m_cnt, m_rejects;
  int m_hits = 0;
  int pulses = 0;
  logic prev_add = 1'b0;

  always #5 clk = ~clk;

  apple_gen_if bus();

  apple_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int l);
    return (l >> 1) ^ (((l % 2) == 1) ? 'hB400 : 0);
  endfunction

  task automatic place_at(input int x, input int y);
    m_ax      = x;
    m_ay      = y;
    m_valid   = 1;
    m_rejects = 0;
    m_mode    = M_SHOWING;
  endtask

  // Advance the game model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int cur, cx, cy, hx, hy, gs;
    if (rst) begin
      m_lfsr = SEED; m_mode = M_IDLE; m_ax = 0; m_ay = 0; m_valid = 0;
      m_add_left = 0; m_cnt = 0; m_rejects = 0;
      return;
    end
    cur    = m_lfsr;
    m_lfsr = lfsr_next(cur);
    gs = int'(bus.game_status);
    hx = int'(bus.head_x);
    hy = int'(bus.head_y);
    if (gs == 0) begin
      m_mode = M_IDLE; m_valid = 0; m_add_left = 0; m_cnt = 0; m_rejects = 0;
      return;
    end
    if (m_mode == M_EATING) begin
      m_add_left--;
      if (m_add_left == 0) m_mode = M_PLACING;
      return;
    end
    if (gs != 2) return;
    if (m_mode == M_IDLE) begin
      m_mode = M_PLACING;
    end else if (m_mode == M_PLACING) begin
      cx = cur % 64;
      cy = (cur / 256) % 64;
      if (cx >= X_MIN && cx <= X_MAX && cy >= Y_MIN && cy <= Y_MAX && !(cx == hx && cy == hy))
        place_at(cx, cy);
      else if (m_rejects == MAX_TRIES) begin
        if (hx == X_MIN && hy == Y_MIN) place_at(X_MAX, Y_MAX);
        else place_at(X_MIN, Y_MIN);
      end else
        m_rejects++;
    end else if (m_mode == M_SHOWING && hx == m_ax && hy == m_ay) begin
      m_valid    = 0;
      m_add_left = ADD_HOLD;
      m_cnt      = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_hits++;
      m_mode     = M_EATING;
    end
  endtask

  task automatic check_all();
    int px, py, pix;
    px  = int'(bus.x_pos);
    py  = int'(bus.y_pos);
    pix = (m_valid == 1 && px < 640 && py < 480 && px / 16 == m_ax && py / 16 == m_ay) ? 1 : 0;
    check_val("apple_x",     32'(bus.apple_x),     32'(m_ax));
    check_val("apple_y",     32'(bus.apple_y),     32'(m_ay));
    check_val("apple_valid", 32'(bus.apple_valid), 32'(m_valid));
    check_val("add_cube",    32'(bus.add_cube),    (m_add_left > 0) ? 32'd1 : 32'd0);
    check_val("eat_count",   32'(bus.eat_count),   32'(m_cnt));
    check_val("apple_pix",   32'(bus.apple_pix),   32'(pix));
    if (bus.add_cube === 1'b1 && prev_add === 1'b0) pulses++;
    prev_add = bus.add_cube;
  endtask

  task automatic drive(input int restart_pct, input int pause_pct, input int hit_pct);
    int r, x, y;
    r = $urandom_range(0, 99);
    if (r < restart_pct) bus.game_status = 2'b00;
    else if (r < restart_pct + pause_pct) bus.game_status = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b11;
    else bus.game_status = 2'b10;
    r = $urandom_range(0, 99);
    if (r < hit_pct) begin
      bus.head_x = 6'(m_ax);
      bus.head_y = 6'(m_ay);
    end else if (r < hit_pct + 10) begin
      bus.head_x = 6'd1;
      bus.head_y = 6'd1;
    end else begin
      bus.head_x = 6'($urandom_range(0, 39));
      bus.head_y = 6'($urandom_range(0, 29));
    end
    if ($urandom_range(0, 3) == 0) begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
    end else begin
      x = m_ax * 16 + $urandom_range(0, 23) - 4;
      y = m_ay * 16 + $urandom_range(0, 23) - 4;
    end
    bus.x_pos = 10'((x < 0) ? 0 : x);
    bus.y_pos = 10'((y < 0) ? 0 : y);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus.game_status = 2'b10;
    bus.head_x      = 6'd10;
    bus.head_y      = 6'd5;
    bus.x_pos       = 10'd0;
    bus.y_pos       = 10'd0;
    rst             = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;

    // First placement with the head parked at (10,5)
    for (int i = 0; i < 70; i++) begin
      cycle();
      if (bus.apple_valid === 1'b1) break;
    end
    check_val("first_place", 32'(bus.apple_valid), 32'd1);

    // Mixed play, pauses, restarts and one mid-game reset
    for (int i = 0; i < 2500; i++) begin
      drive(3, 6, 40);
      if (i == 1200) rst = 1'b1;
      if (i == 1202) rst = 1'b0;
      cycle();
    end

    // Long uninterrupted game driving the counter into saturation
    m_hits = 0;
    pulses = 0;
    for (int i = 0; i < 9000; i++) begin
      drive(0, 4, 90);
      cycle();
      if (m_hits >= 262 && m_add_left == 0) break;
    end
    check_val("eat_sat",    32'(bus.eat_count), 32'd255);
    check_val("add_pulses", 32'(pulses),        32'(m_hits));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
